// File: rtl/fifo_pkg.sv
// Shared definitions for the byte-FIFO word packer: default width, slot encoding
// and the lanes-filled to keep-mask helper.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;
  localparam int unsigned MAX_LANES          = 32;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Mask with the low `lanes` bits set; callers truncate to their lane count.
  function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned lanes);
    logic [MAX_LANES-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < lanes) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read port plus valid/ready word output of the packer, grouped as one bundle.
interface fifo_word_packer_if #(
  parameter int unsigned DATA_WIDTH     = fifo_pkg::DATA_WIDTH_DEFAULT,
  parameter int unsigned BYTES_PER_WORD = 4
);

  logic                                 fifo_empty;
  logic [DATA_WIDTH-1:0]                fifo_data;
  logic                                 fifo_read_en;
  logic                                 flush;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] out_data;
  logic [BYTES_PER_WORD-1:0]            out_keep;

  modport master (
    input  fifo_empty, fifo_data, flush, out_ready,
    output fifo_read_en, out_valid, out_data, out_keep
  );

  modport slave (
    output fifo_empty, fifo_data, flush, out_ready,
    input  fifo_read_en, out_valid, out_data, out_keep
  );

endinterface

// File: rtl/packer_idle_timer.sv
// Saturating idle counter: clear wins over enable, done while held at LIMIT.
// LIMIT of 0 disables the counter and keeps done low.
module packer_idle_timer #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CNT_WIDTH = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(LIMIT);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (LIMIT != 0) && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign done = (LIMIT != 0) && (count_q == CNT_MAX);

endmodule

// File: rtl/fifo_word_packer.sv
// Drains a show-ahead byte FIFO and packs bytes little-endian into keep-masked words,
// emitting partial words on flush or idle timeout.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned TIMEOUT        = 8
) (
  input logic                clk,
  input logic                reset,
  fifo_word_packer_if.master bus
);

  localparam int unsigned WORD_WIDTH = DATA_WIDTH * BYTES_PER_WORD;
  localparam int unsigned IDX_WIDTH  = $clog2(BYTES_PER_WORD + 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BYTES_PER_WORD - 1);

  slot_state_e               slot_q, slot_d;
  logic [WORD_WIDTH-1:0]     asm_data_q, asm_data_d, asm_merged;
  logic [IDX_WIDTH-1:0]      asm_idx_q, asm_idx_d;
  logic                      flush_pending_q, flush_pending_d;
  logic [WORD_WIDTH-1:0]     out_data_q, out_data_d;
  logic [BYTES_PER_WORD-1:0] out_keep_q, out_keep_d;
  logic [BYTES_PER_WORD-1:0] partial_keep;

  logic out_valid, slot_free, accept, has_partial;
  logic pop, pop_last, partial_emit, load, timer_done;

  assign out_valid   = (slot_q == SLOT_FULL);
  assign slot_free   = !out_valid || bus.out_ready;
  assign accept      = out_valid && bus.out_ready;
  assign has_partial = (asm_idx_q != '0);

  // The last lane may only be popped when the completed word has somewhere to go.
  assign pop = !reset && !bus.fifo_empty && !flush_pending_q &&
               !((asm_idx_q == LAST_IDX) && !slot_free);
  assign pop_last     = pop && (asm_idx_q == LAST_IDX);
  assign partial_emit = has_partial && !pop && slot_free &&
                        (flush_pending_q || bus.flush || timer_done);
  assign load         = pop_last || partial_emit;
  assign partial_keep = BYTES_PER_WORD'(keep_mask(32'(asm_idx_q)));

  always_comb begin
    asm_merged = asm_data_q;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (asm_idx_q == IDX_WIDTH'(k)) asm_merged[k*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data;
    end
  end

  // Assembly lanes are cleared on every hand-off so unfilled lanes read as zero.
  always_comb begin
    asm_data_d      = asm_data_q;
    asm_idx_d       = asm_idx_q;
    flush_pending_d = flush_pending_q;
    out_data_d      = out_data_q;
    out_keep_d      = out_keep_q;

    if (pop_last) begin
      out_data_d = asm_merged;
      out_keep_d = '1;
      asm_data_d = '0;
      asm_idx_d  = '0;
    end else if (pop) begin
      asm_data_d = asm_merged;
      asm_idx_d  = asm_idx_q + IDX_WIDTH'(1);
    end else if (partial_emit) begin
      out_data_d = asm_data_q;
      out_keep_d = partial_keep;
      asm_data_d = '0;
      asm_idx_d  = '0;
    end

    // A flush that completes a full word leaves nothing behind to flush.
    if (partial_emit) begin
      flush_pending_d = 1'b0;
    end else if (bus.flush && !pop_last && (has_partial || pop)) begin
      flush_pending_d = 1'b1;
    end
  end

  always_comb begin
    slot_d = slot_q;
    unique case (slot_q)
      SLOT_EMPTY: if (load) slot_d = SLOT_FULL;
      SLOT_FULL:  if (accept && !load) slot_d = SLOT_EMPTY;
      default:    slot_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q          <= SLOT_EMPTY;
      asm_data_q      <= '0;
      asm_idx_q       <= '0;
      flush_pending_q <= 1'b0;
      out_data_q      <= '0;
      out_keep_q      <= '0;
    end else begin
      slot_q          <= slot_d;
      asm_data_q      <= asm_data_d;
      asm_idx_q       <= asm_idx_d;
      flush_pending_q <= flush_pending_d;
      out_data_q      <= out_data_d;
      out_keep_q      <= out_keep_d;
    end
  end

  packer_idle_timer #(
    .LIMIT (TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (pop || load),
    .enable (has_partial && !pop),
    .done   (timer_done)
  );

  assign bus.fifo_read_en = pop;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_data_q;
  assign bus.out_keep     = out_keep_q;

endmodule
